pipeline_hazard_controller: RTL and testbench

// Central stall/flush sequencer for the 5-stage pipeline. It drives the write

---
 rtl/pipeline_hazard_controller.sv | 92 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, branch flush and memory freeze sequencing for a 5-stage pipeline
module pipeline_hazard_controller #(
  parameter int REG_ADDR_LEN = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] id_rs1,
  input  logic [REG_ADDR_LEN-1:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic                    ex_mem_read,
  input  logic [REG_ADDR_LEN-1:0] ex_rd,
  input  logic                    branch_taken,
  input  logic                    mem_busy,
  output logic                    pc_write_en,
  output logic                    if_id_write_en,
  output logic                    if_id_flush,
  output logic                    id_ex_bubble,
  output logic                    ex_mem_write_en,
  output logic [CNT_WIDTH-1:0]    stall_cycles,
  output logic [CNT_WIDTH-1:0]    flush_events
);
  typedef enum logic [1:0] {RUN, FLUSH, FREEZE} state_t;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);
  state_t state_q, state_d, saved_q, saved_d, eff;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d, fev_q, fev_d;
  logic load_use, accept;
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
  assign stall_cycles = stall_q;
  assign flush_events = fev_q;
  always_comb begin
    eff = (state_q == FREEZE) ? saved_q : state_q;
    state_d = RUN;
    saved_d = saved_q;
    cnt_d = cnt_q;
    accept = 1'b0;
    pc_write_en = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_write_en = 1'b1;
    if (rst) begin
      pc_write_en = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_write_en = 1'b0;
    end else if (mem_busy) begin
      pc_write_en = 1'b0;
      if_id_write_en = 1'b0;
      ex_mem_write_en = 1'b0;
      state_d = FREEZE;
      saved_d = eff;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
      accept = 1'b1;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_d = FLUSH_INIT;
    end else if (eff == FLUSH) begin
      if_id_flush = 1'b1;
      cnt_d = cnt_q - FW'(1);
      state_d = (cnt_q == FW'(1)) ? RUN : FLUSH;
    end else if (load_use) begin
      pc_write_en = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble = 1'b1;
    end
    stall_d = (!pc_write_en && stall_q != '1) ? stall_q + CNT_WIDTH'(1) : stall_q;
    fev_d = (accept && fev_q != '1) ? fev_q + CNT_WIDTH'(1) : fev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q <= '0;
      stall_q <= '0;
      fev_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      fev_q <= fev_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks of stall, flush, freeze, reset and counter saturation
module tb_pipeline_hazard_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic branch_taken = 1'b0, mem_busy = 1'b0;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_write_en;
  logic [3:0] stall_cycles, flush_events;
  logic [4:0] ctl;
  int checks = 0;
  int fails = 0;
  pipeline_hazard_controller #(.REG_ADDR_LEN(3), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_mem_write_en(ex_mem_write_en), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );
  // ctl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_write_en}
  assign ctl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_write_en};
  always #5 clk = ~clk;
  task automatic set_in(input logic b, input logic br, input logic mr, input logic [2:0] rd,
                        input logic [2:0] r1, input logic [2:0] r2, input logic u1, input logic u2);
    mem_busy = b; branch_taken = br; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    @(negedge clk);
  endtask
  task automatic adv;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b00110) begin fails++; $display("FAIL reset_ctl_c1 got %b want %b", ctl, 5'b00110); end
    adv;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b00110) begin fails++; $display("FAIL reset_ctl_c2 got %b want %b", ctl, 5'b00110); end
    adv;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL reset_release_ctl got %b want %b", ctl, 5'b11001); end
    checks++; if (stall_cycles !== 4'd0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
    checks++; if (flush_events !== 4'd0) begin fails++; $display("FAIL reset_flush_ev got %0d want 0", flush_events); end
    adv;
  endtask
  task automatic test_load_use;
    set_in(0, 0, 1, 3, 0, 3, 0, 1);
    checks++; if (ctl !== 5'b00011) begin fails++; $display("FAIL lu_rs2_ctl got %b want %b", ctl, 5'b00011); end
    adv;
    checks++; if (stall_cycles !== 4'd1) begin fails++; $display("FAIL lu_rs2_stall got %0d want 1", stall_cycles); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL lu_after_ctl got %b want %b", ctl, 5'b11001); end
    adv;
  endtask
  task automatic test_no_hazard;
    set_in(0, 0, 1, 0, 0, 0, 0, 1);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL nh_rd0_ctl got %b want %b", ctl, 5'b11001); end
    adv;
    set_in(0, 0, 1, 3, 0, 3, 0, 0);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL nh_unused_ctl got %b want %b", ctl, 5'b11001); end
    adv;
    set_in(0, 0, 0, 3, 0, 3, 0, 1);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL nh_noload_ctl got %b want %b", ctl, 5'b11001); end
    adv;
    checks++; if (stall_cycles !== 4'd1) begin fails++; $display("FAIL nh_stall got %0d want 1", stall_cycles); end
    set_in(0, 0, 1, 5, 5, 2, 1, 0);
    checks++; if (ctl !== 5'b00011) begin fails++; $display("FAIL lu_rs1_ctl got %b want %b", ctl, 5'b00011); end
    adv;
    checks++; if (stall_cycles !== 4'd2) begin fails++; $display("FAIL lu_rs1_stall got %0d want 2", stall_cycles); end
  endtask
  task automatic test_flush;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11111) begin fails++; $display("FAIL fl_first_ctl got %b want %b", ctl, 5'b11111); end
    adv;
    checks++; if (flush_events !== 4'd1) begin fails++; $display("FAIL fl_events1 got %0d want 1", flush_events); end
    set_in(0, 0, 1, 3, 0, 3, 0, 1);
    checks++; if (ctl !== 5'b11101) begin fails++; $display("FAIL fl_second_ctl got %b want %b", ctl, 5'b11101); end
    adv;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL fl_done_ctl got %b want %b", ctl, 5'b11001); end
    adv;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    adv;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11111) begin fails++; $display("FAIL fl_restart_ctl got %b want %b", ctl, 5'b11111); end
    adv;
    checks++; if (flush_events !== 4'd3) begin fails++; $display("FAIL fl_events3 got %0d want 3", flush_events); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11101) begin fails++; $display("FAIL fl_ext_ctl got %b want %b", ctl, 5'b11101); end
    adv;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL fl_ext_done_ctl got %b want %b", ctl, 5'b11001); end
    adv;
    checks++; if (stall_cycles !== 4'd2) begin fails++; $display("FAIL fl_stall got %0d want 2", stall_cycles); end
  endtask
  task automatic test_freeze_in_flush;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    adv;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL fz_ctl_c%0d got %b want %b", i, ctl, 5'b00000); end
      adv;
    end
    checks++; if (stall_cycles !== 4'd5) begin fails++; $display("FAIL fz_stall got %0d want 5", stall_cycles); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11101) begin fails++; $display("FAIL fz_resume_ctl got %b want %b", ctl, 5'b11101); end
    adv;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL fz_run_ctl got %b want %b", ctl, 5'b11001); end
    adv;
    checks++; if (flush_events !== 4'd4) begin fails++; $display("FAIL fz_events got %0d want 4", flush_events); end
  endtask
  task automatic test_priority;
    set_in(1, 1, 1, 3, 0, 3, 0, 1);
    checks++; if (ctl !== 5'b00000) begin fails++; $display("FAIL pr_freeze_ctl got %b want %b", ctl, 5'b00000); end
    adv;
    checks++; if (flush_events !== 4'd4) begin fails++; $display("FAIL pr_events_hold got %0d want 4", flush_events); end
    checks++; if (stall_cycles !== 4'd6) begin fails++; $display("FAIL pr_stall got %0d want 6", stall_cycles); end
    set_in(0, 1, 1, 3, 0, 3, 0, 1);
    checks++; if (ctl !== 5'b11111) begin fails++; $display("FAIL pr_branch_ctl got %b want %b", ctl, 5'b11111); end
    adv;
    checks++; if (flush_events !== 4'd5) begin fails++; $display("FAIL pr_events got %0d want 5", flush_events); end
    set_in(0, 0, 1, 3, 0, 3, 0, 1);
    checks++; if (ctl !== 5'b11101) begin fails++; $display("FAIL pr_flush_lu_ctl got %b want %b", ctl, 5'b11101); end
    adv;
    set_in(0, 0, 1, 3, 0, 3, 0, 1);
    checks++; if (ctl !== 5'b00011) begin fails++; $display("FAIL pr_run_lu_ctl got %b want %b", ctl, 5'b00011); end
    adv;
    checks++; if (stall_cycles !== 4'd7) begin fails++; $display("FAIL pr_stall2 got %0d want 7", stall_cycles); end
  endtask
  task automatic test_reset_mid_freeze;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    adv;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    adv;
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b00110) begin fails++; $display("FAIL rm_rst_ctl got %b want %b", ctl, 5'b00110); end
    adv;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 5'b11001) begin fails++; $display("FAIL rm_run_ctl got %b want %b", ctl, 5'b11001); end
    checks++; if (stall_cycles !== 4'd0) begin fails++; $display("FAIL rm_stall got %0d want 0", stall_cycles); end
    checks++; if (flush_events !== 4'd0) begin fails++; $display("FAIL rm_events got %0d want 0", flush_events); end
    adv;
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 17; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      adv;
    end
    checks++; if (stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_stall got %0d want 15", stall_cycles); end
    for (int i = 0; i < 17; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, 0);
      adv;
    end
    checks++; if (flush_events !== 4'd15) begin fails++; $display("FAIL sat_events got %0d want 15", flush_events); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    adv;
    checks++; if (stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_stall_hold got %0d want 15", stall_cycles); end
  endtask
  initial begin
    test_reset;
    test_load_use;
    test_no_hazard;
    test_flush;
    test_freeze_in_flush;
    test_priority;
    test_reset_mid_freeze;
    test_saturation;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
